// File: rtl/row_by_vector_sched_pkg.sv
// -----------------------------------------------------------------------------
// rbv_sched_pkg
// Shared types and constants for the row_by_vector_sched sequencer.
//   - rbv_state_e : sequencer FSM state encoding
//   - RBV_DATA_W  : width of one dot-product result / operand element
//   - RBV_VEC_W   : width of one packed three-element row or vector operand
//   - rbv_clog2   : address-width helper, never returns less than 1
// -----------------------------------------------------------------------------
package rbv_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } rbv_state_e;

  localparam int RBV_DATA_W = 32;
  localparam int RBV_VEC_W  = 96;

  // Ceiling log2 with a floor of 1 so a one-row memory still gets an address bit.
  function automatic int rbv_clog2(input int value);
    int width;
    width = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) width = i + 1;
    end
    if (width < 1) width = 1;
    return width;
  endfunction

endpackage

// File: rtl/row_by_vector_sched_if.sv
// -----------------------------------------------------------------------------
// row_by_vector_sched_if
// Bundles the sequencer's control, row-memory, datapath and result-memory
// signals.
//   slave  : the sequencer side (takes start/n_rows/dp_result, drives the rest)
//   master : the surrounding system (CG controller, memories, datapath)
// Signals:
//   start, n_rows           run request and row count
//   row_rd_en, row_addr     row-memory read strobe and index
//   dp_result               result from the row_by_vector datapath
//   res_wr_en, res_addr,
//   res_data                result-memory write port
//   busy, done, err_start   status back to the controller
// -----------------------------------------------------------------------------
interface row_by_vector_sched_if
  import rbv_sched_pkg::*;
#(
  parameter int AW = 4
);

  logic                  start;
  logic [AW:0]           n_rows;
  logic                  row_rd_en;
  logic [AW-1:0]         row_addr;
  logic [RBV_DATA_W-1:0] dp_result;
  logic                  res_wr_en;
  logic [AW-1:0]         res_addr;
  logic [RBV_DATA_W-1:0] res_data;
  logic                  busy;
  logic                  done;
  logic                  err_start;

  modport slave (
    input  start, n_rows, dp_result,
    output row_rd_en, row_addr, res_wr_en, res_addr, res_data,
           busy, done, err_start
  );

  modport master (
    output start, n_rows, dp_result,
    input  row_rd_en, row_addr, res_wr_en, res_addr, res_data,
           busy, done, err_start
  );

endinterface

// File: rtl/row_by_vector_sched_tag_pipe.sv
// -----------------------------------------------------------------------------
// rbv_tag_pipe
// Fixed-depth {valid, addr} delay line that follows each row through the
// memory read and the unstallable datapath, so the result index pops out in
// the same cycle as the matching result.
// Ports:
//   clk, rst_n            clock, asynchronous active-low clear of every stage
//   in_valid, in_addr     loaded into stage 0 each cycle
//   out_valid, out_addr   last stage (drives the result write port)
//   any_valid             some entry is still queued behind the last stage
// DEPTH must be at least 2.
// -----------------------------------------------------------------------------
module rbv_tag_pipe #(
  parameter int DEPTH = 17,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [AW-1:0] in_addr,
  output logic          out_valid,
  output logic [AW-1:0] out_addr,
  output logic          any_valid
);

  logic [DEPTH-1:0] valid_q;
  logic [AW-1:0]    addr_q [DEPTH];

  // Plain shift register; reset wipes every tag so in-flight results are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) addr_q[i] <= '0;
    end else begin
      valid_q[0] <= in_valid;
      addr_q[0]  <= in_addr;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        addr_q[i]  <= addr_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_addr  = addr_q[DEPTH-1];

  // The last stage is excluded: when only it holds a tag, that write is
  // happening now and the line is empty from the next cycle on, which lets
  // the sequencer finish exactly one cycle after the final write.
  assign any_valid = |valid_q[DEPTH-2:0];

endmodule

// File: rtl/row_by_vector_sched.sv
// -----------------------------------------------------------------------------
// row_by_vector_sched
// Streams matrix rows 0..n-1 through the three-wide row_by_vector datapath,
// one row per cycle, and writes each result to the result memory at the
// matching row index. A tag delay line matches the read + datapath latency.
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   bus          row_by_vector_sched_if.slave (start/n_rows, row read port,
//                dp_result, result write port, busy/done/err_start)
//   perf_cycles  (only with RBV_SCHED_PERF_EN) busy-cycle count of last run
// Optional feature macro: RBV_SCHED_PERF_EN
// -----------------------------------------------------------------------------
module row_by_vector_sched
  import rbv_sched_pkg::*;
#(
  parameter int N_ROWS     = 12,
  parameter int RD_LATENCY = 1,
  parameter int DP_LATENCY = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  row_by_vector_sched_if.slave bus
`ifdef RBV_SCHED_PERF_EN
  ,
  output logic [31:0]          perf_cycles
`endif
);

  localparam int          AW    = rbv_clog2(N_ROWS);
  localparam int          DEPTH = RD_LATENCY + DP_LATENCY;
  localparam logic [AW:0] N_MAX = (AW+1)'(N_ROWS);

  rbv_state_e    state_q;
  rbv_state_e    state_d;
  logic [AW-1:0] addr_q;
  logic [AW:0]   n_q;
  logic          accept;
  logic          issuing;
  logic          last_issue;
  logic          tag_valid;
  logic [AW-1:0] tag_addr;
  logic          tag_pending;

  assign accept     = (state_q == IDLE) && bus.start;
  assign issuing    = (state_q == ISSUE);
  assign last_issue = issuing && ({1'b0, addr_q} == (n_q - 1'b1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Row counter and latched run length; the count is only taken on an
  // accepted start so rejected starts cannot disturb a run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      n_q    <= '0;
    end else if (accept) begin
      addr_q <= '0;
      n_q    <= (bus.n_rows > N_MAX) ? N_MAX : bus.n_rows;
    end else if (issuing) begin
      addr_q <= addr_q + 1'b1;
    end
  end

  // Next state and all bus outputs. Writes come straight from the tag line's
  // last stage; res_data is zeroed outside writes so idle and reset leave
  // every output at 0.
  always_comb begin
    state_d       = state_q;
    bus.row_rd_en = 1'b0;
    bus.row_addr  = '0;
    bus.done      = 1'b0;
    bus.busy      = (state_q != IDLE);
    bus.err_start = bus.start && (state_q != IDLE);
    bus.res_wr_en = tag_valid;
    bus.res_addr  = tag_valid ? tag_addr : '0;
    bus.res_data  = tag_valid ? bus.dp_result : '0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) state_d = (bus.n_rows == '0) ? FIN : ISSUE;
      end
      ISSUE: begin
        bus.row_rd_en = 1'b1;
        bus.row_addr  = addr_q;
        if (last_issue) state_d = DRAIN;
      end
      DRAIN: begin
        if (!tag_pending) state_d = FIN;
      end
      FIN: begin
        bus.done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  rbv_tag_pipe #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_tag_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (issuing),
    .in_addr   (addr_q),
    .out_valid (tag_valid),
    .out_addr  (tag_addr),
    .any_valid (tag_pending)
  );

`ifdef RBV_SCHED_PERF_EN
  // Busy-cycle counter: restarts on each accepted start and holds after done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             perf_cycles <= '0;
    else if (accept)        perf_cycles <= '0;
    else if (state_q != IDLE) perf_cycles <= perf_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_row_by_vector_sched.sv
// -----------------------------------------------------------------------------
// tb_row_by_vector_sched
// Self-checking bench for row_by_vector_sched. A behavioural datapath returns
// the dot product of the row that was read, RD_LATENCY+DP_LATENCY cycles
// later; expected read/write/done/busy timing is computed from the start cycle.
// Optional feature macro: RBV_SCHED_PERF_EN
// -----------------------------------------------------------------------------
module tb_row_by_vector_sched;
  import rbv_sched_pkg::*;

  localparam int N_ROWS     = 12;
  localparam int RD_LATENCY = 1;
  localparam int DP_LATENCY = 16;
  localparam int AW         = rbv_clog2(N_ROWS);
  localparam int LAT        = RD_LATENCY + DP_LATENCY;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   gcyc = 0;

  logic [RBV_DATA_W-1:0] dp_sched [int];
  logic [RBV_VEC_W-1:0]  mat_a [N_ROWS];
  logic [RBV_VEC_W-1:0]  vec_p;

  logic                  obs_rd, obs_wr, obs_done, obs_busy, obs_err;
  logic [AW-1:0]         obs_raddr, obs_waddr;
  logic [RBV_DATA_W-1:0] obs_wdata;

`ifdef RBV_SCHED_PERF_EN
  logic [31:0] perf_cycles;
`endif

  row_by_vector_sched_if #(.AW(AW)) bus ();

  row_by_vector_sched #(
    .N_ROWS     (N_ROWS),
    .RD_LATENCY (RD_LATENCY),
    .DP_LATENCY (DP_LATENCY)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef RBV_SCHED_PERF_EN
    ,
    .perf_cycles (perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [RBV_DATA_W-1:0] dot_row(input int k);
    logic [RBV_DATA_W-1:0] acc;
    acc = '0;
    for (int j = 0; j < 3; j++)
      acc += mat_a[k][32*j +: 32] * vec_p[32*j +: 32];
    return acc;
  endfunction

  task automatic fill_memories();
    for (int k = 0; k < N_ROWS; k++)
      mat_a[k] = {$urandom(), $urandom(), $urandom()};
    vec_p = {$urandom(), $urandom(), $urandom()};
  endtask

  // One cycle: drive the datapath output, sample mid-cycle, advance to edge+1.
  task automatic step_cycle();
    if (dp_sched.exists(gcyc)) bus.dp_result = dp_sched[gcyc];
    else                       bus.dp_result = $urandom();
    #4;
    obs_rd    = bus.row_rd_en;
    obs_raddr = bus.row_addr;
    obs_wr    = bus.res_wr_en;
    obs_waddr = bus.res_addr;
    obs_wdata = bus.res_data;
    obs_done  = bus.done;
    obs_busy  = bus.busy;
    obs_err   = bus.err_start;
    if (obs_rd) begin
      if (int'(obs_raddr) < N_ROWS) dp_sched[gcyc + LAT] = dot_row(int'(obs_raddr));
      else                          dp_sched[gcyc + LAT] = 32'hDEAD_BEEF;
    end
    @(posedge clk);
    #1;
    gcyc++;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    total++;
    if (bus.row_rd_en !== 1'b0 || bus.res_wr_en !== 1'b0 || bus.busy !== 1'b0 ||
        bus.done !== 1'b0 || bus.err_start !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_ctrl got rd=%b wr=%b busy=%b done=%b err=%b want all 0",
               bus.row_rd_en, bus.res_wr_en, bus.busy, bus.done, bus.err_start);
    end
    total++;
    if (bus.row_addr !== '0 || bus.res_addr !== '0 || bus.res_data !== '0) begin
      bad++;
      $display("[TB] FAIL reset_data got raddr=%0d waddr=%0d wdata=%h want 0",
               bus.row_addr, bus.res_addr, bus.res_data);
    end
`ifdef RBV_SCHED_PERF_EN
    total++;
    if (perf_cycles !== 32'd0) begin
      bad++;
      $display("[TB] FAIL reset_perf got %0d want 0", perf_cycles);
    end
`endif
    rst_n = 1'b1;
    step_cycle();
    total++;
    if (obs_busy !== 1'b0 || obs_done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL idle_after_reset got busy=%b done=%b want 0 0", obs_busy, obs_done);
    end
  endtask

  // One run started at relative cycle 0; extra_rel >= 1 adds a rejected start.
  task automatic test_run(input string name, input int n_req, input int extra_rel);
    int   n_eff, done_rel, k;
    logic exp_rd, exp_wr, exp_busy, exp_done, exp_err, started;
    n_eff    = (n_req > N_ROWS) ? N_ROWS : n_req;
    done_rel = (n_eff == 0) ? 1 : 1 + n_eff + LAT;
    for (int r = 0; r <= done_rel; r++) begin
      started    = (r == 0) || (r == extra_rel);
      bus.start  = started;
      bus.n_rows = (r == 0) ? (AW+1)'(n_req) : (AW+1)'($urandom_range(0, 31));
      step_cycle();
      bus.start  = 1'b0;
      exp_rd   = (r >= 1) && (r <= n_eff);
      exp_wr   = (n_eff > 0) && (r >= 1 + LAT) && (r <= n_eff + LAT);
      exp_done = (r == done_rel);
      exp_busy = (r >= 1);
      exp_err  = started && (r >= 1);
      total++;
      if (obs_rd !== exp_rd) begin
        bad++;
        $display("[TB] FAIL %s rd_en r=%0d got %b want %b", name, r, obs_rd, exp_rd);
      end
      if (exp_rd) begin
        total++;
        if (obs_raddr !== AW'(r - 1)) begin
          bad++;
          $display("[TB] FAIL %s row_addr r=%0d got %0d want %0d", name, r, obs_raddr, r - 1);
        end
      end
      total++;
      if (obs_wr !== exp_wr) begin
        bad++;
        $display("[TB] FAIL %s wr_en r=%0d got %b want %b", name, r, obs_wr, exp_wr);
      end
      if (exp_wr) begin
        k = r - 1 - LAT;
        total++;
        if (obs_waddr !== AW'(k) || obs_wdata !== dot_row(k)) begin
          bad++;
          $display("[TB] FAIL %s write r=%0d got addr=%0d data=%h want addr=%0d data=%h",
                   name, r, obs_waddr, obs_wdata, k, dot_row(k));
        end
      end
      total++;
      if (obs_done !== exp_done || obs_busy !== exp_busy || obs_err !== exp_err) begin
        bad++;
        $display("[TB] FAIL %s status r=%0d got done=%b busy=%b err=%b want %b %b %b",
                 name, r, obs_done, obs_busy, obs_err, exp_done, exp_busy, exp_err);
      end
    end
`ifdef RBV_SCHED_PERF_EN
    total++;
    if (perf_cycles !== 32'(done_rel)) begin
      bad++;
      $display("[TB] FAIL %s perf_cycles got %0d want %0d", name, perf_cycles, done_rel);
    end
`endif
  endtask

  task automatic test_mid_run_reset();
    bus.start  = 1'b1;
    bus.n_rows = (AW+1)'(12);
    step_cycle();
    bus.start = 1'b0;
    for (int r = 1; r < 10; r++) step_cycle();
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.row_rd_en !== 1'b0 || bus.res_wr_en !== 1'b0 || bus.busy !== 1'b0 ||
        bus.done !== 1'b0 || bus.err_start !== 1'b0 || bus.row_addr !== '0 ||
        bus.res_addr !== '0 || bus.res_data !== '0) begin
      bad++;
      $display("[TB] FAIL midrun_reset got rd=%b wr=%b busy=%b done=%b raddr=%0d want all 0",
               bus.row_rd_en, bus.res_wr_en, bus.busy, bus.done, bus.row_addr);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    gcyc += 2;
    rst_n = 1'b1;
    dp_sched.delete();
    for (int r = 0; r < LAT + 8; r++) begin
      step_cycle();
      total++;
      if (obs_wr !== 1'b0 || obs_rd !== 1'b0 || obs_busy !== 1'b0) begin
        bad++;
        $display("[TB] FAIL post_reset_quiet c=%0d got wr=%b rd=%b busy=%b want 0 0 0",
                 r, obs_wr, obs_rd, obs_busy);
      end
    end
    test_run("after_reset", 3, -1);
  endtask

  task automatic test_random_runs();
    int n_req, d_rel, extra;
    for (int i = 0; i < 4; i++) begin
      fill_memories();
      n_req = $urandom_range(0, 20);
      d_rel = (n_req == 0) ? 1 : 1 + ((n_req > N_ROWS) ? N_ROWS : n_req) + LAT;
      extra = ($urandom_range(0, 1) == 1) ? $urandom_range(1, d_rel) : -1;
      test_run("random", n_req, extra);
    end
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.n_rows    = '0;
    bus.dp_result = '0;
    fill_memories();
    test_reset();
    test_run("nominal", 12, -1);
    test_run("zero_rows", 0, -1);
    test_run("single_row", 1, -1);
    test_run("start_while_busy", 12, 5);
    test_run("clamp", 20, -1);
    test_run("start_in_fin", 2, 1 + 2 + LAT);
    test_mid_run_reset();
    test_random_runs();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
